// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - LEGv8 immediate format codes and opcode match constants
package imm_pkg;

    localparam int FMT_W = 3;

    typedef enum logic [FMT_W-1:0] {
        FMT_NONE = 3'd0,
        FMT_B    = 3'd1,
        FMT_CB   = 3'd2,
        FMT_D    = 3'd3,
        FMT_I    = 3'd4,
        FMT_IM   = 3'd5
    } fmt_t;

    localparam logic [4:0] OP_B      = 5'b00101;     // instruction[30:26]
    localparam logic [6:0] OP_CBZ    = 7'b1011010;   // instruction[31:25]
    localparam logic [7:0] OP_BCOND  = 8'h54;        // instruction[31:24]
    localparam logic [7:0] OP_D      = 8'hF8;        // instruction[31:24]
    localparam logic [4:0] OP_I_ARI  = 5'b10001;     // instruction[28:24]
    localparam logic [5:0] OP_I_LOG  = 6'b100100;    // instruction[28:23]
    localparam logic [7:0] OP_IM     = 8'b10100101;  // instruction[30:23]

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational format classify and immediate extend
module imm_decode
    import imm_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter bit BR_SHIFT = 1'b1
) (
    input  logic [31:0]       instruction,
    output logic [DATA_W-1:0] imm,
    output fmt_t              fmt,
    output logic              err
);

    localparam int         BR_SH = BR_SHIFT ? 2 : 0;
    localparam logic [6:0] DW7   = 7'(DATA_W);

    logic [DATA_W-1:0] b_ext;
    logic [DATA_W-1:0] cb_ext;
    logic [DATA_W-1:0] d_ext;
    logic [DATA_W-1:0] i_ext;
    logic [DATA_W-1:0] im_ext;
    logic [5:0]        im_sh;
    logic              im_ok;

    assign b_ext  = {{(DATA_W-26){instruction[25]}}, instruction[25:0]} << BR_SH;
    assign cb_ext = {{(DATA_W-19){instruction[23]}}, instruction[23:5]} << BR_SH;
    assign d_ext  = {{(DATA_W-9){instruction[20]}}, instruction[20:12]};
    assign i_ext  = {{(DATA_W-12){1'b0}}, instruction[21:10]};
    assign im_sh  = {instruction[22:21], 4'b0000};
    assign im_ext = {{(DATA_W-16){1'b0}}, instruction[20:5]} << im_sh;
    // a half-word slot that lies wholly above DATA_W cannot hold the immediate
    assign im_ok  = {1'b0, im_sh} < DW7;

    always_comb begin
        imm = '0;
        fmt = FMT_NONE;
        err = 1'b0;
        if (instruction[30:26] == OP_B) begin
            fmt = FMT_B;
            imm = b_ext;
        end else if (instruction[31:25] == OP_CBZ || instruction[31:24] == OP_BCOND) begin
            fmt = FMT_CB;
            imm = cb_ext;
        end else if (instruction[31:24] == OP_D && !instruction[21]) begin
            fmt = FMT_D;
            imm = d_ext;
        end else if (instruction[31] &&
                     (instruction[28:24] == OP_I_ARI || instruction[28:23] == OP_I_LOG)) begin
            fmt = FMT_I;
            imm = i_ext;
        end else if (instruction[31] && instruction[30:23] == OP_IM) begin
            fmt = FMT_IM;
            if (im_ok) begin
                imm = im_ext;
            end else begin
                err = 1'b1;
            end
        end else begin
            err = 1'b1;
        end
    end

endmodule

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - two-stage valid/ready immediate generator with flush
module imm_gen
    import imm_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter bit BR_SHIFT = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instruction,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] imm,
    output logic [FMT_W-1:0]  fmt,
    output logic              err
);

    logic              s1_valid;
    logic [31:0]       s1_instr;
    logic              s2_valid;
    logic [DATA_W-1:0] s2_imm;
    fmt_t              s2_fmt;
    logic              s2_err;

    logic [DATA_W-1:0] dec_imm;
    fmt_t              dec_fmt;
    logic              dec_err;
    logic              s2_adv;
    logic              accept;

    imm_decode #(
        .DATA_W   (DATA_W),
        .BR_SHIFT (BR_SHIFT)
    ) u_decode (
        .instruction (s1_instr),
        .imm         (dec_imm),
        .fmt         (dec_fmt),
        .err         (dec_err)
    );

    assign s2_adv   = !s2_valid || out_ready;
    assign in_ready = !flush && (!s1_valid || s2_adv);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_instr <= '0;
            s2_valid <= 1'b0;
            s2_imm   <= '0;
            s2_fmt   <= FMT_NONE;
            s2_err   <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
                s2_imm   <= dec_imm;
                s2_fmt   <= dec_fmt;
                s2_err   <= dec_err;
            end
            if (accept) begin
                s1_valid <= 1'b1;
                s1_instr <= instruction;
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // stale S2 contents after a flush or drain must never be visible
    assign out_valid = s2_valid;
    assign imm       = s2_valid ? s2_imm : '0;
    assign fmt       = s2_valid ? s2_fmt : FMT_NONE;
    assign err       = s2_valid && s2_err;

endmodule

// File: tb/tb_imm_gen.sv
// tb/tb_imm_gen.sv - self-checking bench for imm_gen
module tb_imm_gen;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] instruction;
    logic        out_ready;

    logic        in_ready, out_valid, err;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        in_ready32, out_valid32, err32;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic        in_readynb, out_validnb, errnb;
    logic [63:0] immnb;
    logic [2:0]  fmtnb;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] q[$];

    always #5 clock = ~clock;

    imm_gen #(.DATA_W(64), .BR_SHIFT(1'b1)) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready), .instruction(instruction), .out_valid(out_valid),
        .out_ready(out_ready), .imm(imm), .fmt(fmt), .err(err));

    imm_gen #(.DATA_W(32), .BR_SHIFT(1'b1)) dut32 (
        .clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready32), .instruction(instruction), .out_valid(out_valid32),
        .out_ready(out_ready), .imm(imm32), .fmt(fmt32), .err(err32));

    imm_gen #(.DATA_W(64), .BR_SHIFT(1'b0)) dutnb (
        .clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_readynb), .instruction(instruction), .out_valid(out_validnb),
        .out_ready(out_ready), .imm(immnb), .fmt(fmtnb), .err(errnb));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // reference: field value as a signed/unsigned integer, scaled arithmetically, masked to width
    function automatic void model(input logic [31:0] ins, input int dw, input bit brs,
                                  output logic [63:0] m_imm, output logic [2:0] m_fmt,
                                  output logic m_err);
        longint      v;
        int          hw;
        logic [63:0] mask;
        v = 0; m_fmt = 3'd0; m_err = 1'b0;
        if (ins[30:26] == 5'b00101) begin
            m_fmt = 3'd1; v = longint'($signed(ins[25:0])); if (brs) v = v * 4;
        end else if (ins[31:25] == 7'b1011010 || ins[31:24] == 8'h54) begin
            m_fmt = 3'd2; v = longint'($signed(ins[23:5])); if (brs) v = v * 4;
        end else if (ins[31:24] == 8'hF8 && !ins[21]) begin
            m_fmt = 3'd3; v = longint'($signed(ins[20:12]));
        end else if (ins[31] && (ins[28:24] == 5'b10001 || ins[28:23] == 6'b100100)) begin
            m_fmt = 3'd4; v = longint'(ins[21:10]);
        end else if (ins[31] && ins[30:23] == 8'b10100101) begin
            m_fmt = 3'd5; hw = int'(ins[22:21]);
            if (16 * hw >= dw) m_err = 1'b1;
            else v = longint'(ins[20:5]) * (longint'(1) << (16 * hw));
        end else begin
            m_err = 1'b1;
        end
        mask  = (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << dw) - 64'd1);
        m_imm = 64'(v) & mask;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 5))
            0: gen_instr = {r[31], 5'b00101, r[25:0]};
            1: gen_instr = r[0] ? {7'b1011010, r[24:0]} : {8'h54, r[23:0]};
            2: gen_instr = {8'hF8, r[23:0]};
            3: gen_instr = r[0] ? {1'b1, r[30:29], 5'b10001, r[23:0]}
                                : {1'b1, r[30:29], 6'b100100, r[22:0]};
            4: gen_instr = {1'b1, 8'b10100101, r[22:0]};
            default: gen_instr = r;
        endcase
    endfunction

    task automatic check_out(input logic [31:0] ins);
        logic [63:0] e_imm;
        logic [2:0]  e_fmt;
        logic        e_err;
        model(ins, 64, 1'b1, e_imm, e_fmt, e_err);
        chk("imm64", imm, e_imm); chk("fmt64", 64'(fmt), 64'(e_fmt)); chk("err64", 64'(err), 64'(e_err));
        model(ins, 32, 1'b1, e_imm, e_fmt, e_err);
        chk("valid32", 64'(out_valid32), 64'd1);
        chk("imm32", 64'(imm32), e_imm); chk("fmt32", 64'(fmt32), 64'(e_fmt)); chk("err32", 64'(err32), 64'(e_err));
        model(ins, 64, 1'b0, e_imm, e_fmt, e_err);
        chk("validnb", 64'(out_validnb), 64'd1);
        chk("immnb", immnb, e_imm); chk("fmtnb", 64'(fmtnb), 64'(e_fmt)); chk("errnb", 64'(errnb), 64'(e_err));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_imm"}, imm | 64'(imm32) | immnb, 64'd0);
        chk({tag, "_fmt"}, 64'(fmt | fmt32 | fmtnb), 64'd0);
        chk({tag, "_err"}, 64'(err | err32 | errnb), 64'd0);
    endtask

    // one clock cycle: sample mid-cycle, update scoreboard, step past the edge
    task automatic tick();
        logic exp_ready;
        #2;
        exp_ready = !flush && (q.size() < 2 || out_ready);
        chk("in_ready", 64'(in_ready), 64'(exp_ready));
        chk("in_ready_eq", 64'({in_ready32, in_readynb}), 64'({in_ready, in_ready}));
        if (!out_valid) chk_idle("idle");
        if (out_valid && out_ready) begin
            if (q.size() == 0) chk("spurious_out", 64'(out_valid), 64'd0);
            else check_out(q.pop_front());
        end
        if (flush) q.delete();
        if (in_valid && in_ready) q.push_back(instruction);
        @(posedge clock);
        #1;
    endtask

    task automatic lat_vec(input logic [31:0] ins, input logic [63:0] e64, input logic [63:0] enb,
                           input logic [31:0] e32, input logic [2:0] ef, input logic ee,
                           input logic ee32);
        out_ready = 1'b1; in_valid = 1'b1; instruction = ins;
        tick();
        in_valid = 1'b0; instruction = $urandom();
        #1 chk("lat_edge1", 64'(out_valid), 64'd0);
        tick();
        #1 chk("lat_edge2", 64'(out_valid), 64'd1);
        chk("vec_imm64", imm, e64); chk("vec_immnb", immnb, enb); chk("vec_imm32", 64'(imm32), 64'(e32));
        chk("vec_fmt", 64'(fmt), 64'(ef)); chk("vec_err", 64'(err), 64'(ee)); chk("vec_err32", 64'(err32), 64'(ee32));
        tick();
    endtask

    initial begin
        logic [31:0] bp[4];
        logic [63:0] e_imm;
        logic [2:0]  e_fmt;
        logic        e_err;
        int          idx;
        logic        acc;

        reset_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instruction = '0;
        #1 reset_n = 1'b0;
        #1 chk("rst_valid", 64'({out_valid, out_valid32, out_validnb}), 64'd0);
        chk_idle("rst");
        @(posedge clock); @(posedge clock); #1;
        reset_n = 1'b1;

        lat_vec(32'hF85F8041, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, 32'hFFFF_FFF8, 3'd3, 1'b0, 1'b0);
        lat_vec(32'h17FFFFFF, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFC, 3'd1, 1'b0, 1'b0);
        lat_vec(32'hD2C24680, 64'h0000_1234_0000_0000, 64'h0000_1234_0000_0000, 32'h0, 3'd5, 1'b0, 1'b1);
        lat_vec(32'h913FFC41, 64'h0000_0000_0000_0FFF, 64'h0000_0000_0000_0FFF, 32'h0000_0FFF, 3'd4, 1'b0, 1'b0);
        lat_vec(32'h00000000, 64'h0, 64'h0, 32'h0, 3'd0, 1'b1, 1'b1);
        lat_vec(32'hB4000040, 64'h8, 64'h2, 32'h8, 3'd2, 1'b0, 1'b0);
        lat_vec(32'h54FFFFE0, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFC, 3'd2, 1'b0, 1'b0);

        // backpressure: 4 back-to-back beats, consumer stalled for 3 cycles
        bp[0] = 32'hF85F8041; bp[1] = 32'h913FFC41; bp[2] = 32'h17FFFFFF; bp[3] = 32'hD2C24680;
        idx = 0;
        model(bp[0], 64, 1'b1, e_imm, e_fmt, e_err);
        for (int c = 1; c <= 7; c++) begin
            out_ready = (c >= 4);
            in_valid = (idx < 4);
            instruction = (idx < 4) ? bp[idx] : 32'h0;
            #1;
            if (c == 3) begin
                chk("bp_in_ready_low", 64'(in_ready), 64'd0);
                chk("bp_hold_c3", imm, e_imm);
            end
            if (c == 4) chk("bp_hold_c4", imm, e_imm);
            if (c >= 4) chk("bp_no_gap", 64'(out_valid), 64'd1);
            acc = in_valid && in_ready;
            tick();
            if (acc) idx++;
        end
        chk("bp_accepted", 64'(idx), 64'd4);
        in_valid = 1'b0;
        tick();

        // flush with two beats in flight
        out_ready = 1'b0; in_valid = 1'b1;
        instruction = 32'h17FFFFFF; tick();
        instruction = 32'hF85F8041; tick();
        flush = 1'b1; instruction = 32'h913FFC41;
        #1 chk("flush_in_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1 chk("flush_out_valid", 64'(out_valid | out_valid32 | out_validnb), 64'd0);
        chk_idle("flush");
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        // asynchronous reset mid-stream
        out_ready = 1'b0; in_valid = 1'b1;
        instruction = 32'h17FFFFFF; tick();
        instruction = 32'hD2C24680; tick();
        #2 reset_n = 1'b0;
        #1 chk("arst_out_valid", 64'(out_valid | out_valid32 | out_validnb), 64'd0);
        chk_idle("arst");
        q.delete();
        in_valid = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1; instruction = 32'h913FFC41;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // randomized traffic against the reference model
        for (int i = 0; i < 500; i++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 40) == 0);
            instruction = gen_instr();
            tick();
        end
        flush = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            out_ready = 1'b1;
            tick();
        end
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
